// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the multicycle control unit and its datapath.
// The master side is the control unit: it takes instruction fields and flags and drives the datapath controls.
interface multicycle_control_unit_if #(
  parameter int ALUCTRL_W = 3
);
  logic [5:0]           Opcode;
  logic [5:0]           Funct;
  logic                 Zero;
  logic                 MemReady;
  logic                 IorD;
  logic                 IRWrite;
  logic                 MemWrite;
  logic                 RegWrite;
  logic                 RegDst;
  logic                 MemtoReg;
  logic                 ALUSrcA;
  logic                 PCEn;
  logic [1:0]           ALUSrcB;
  logic [1:0]           PCSrc;
  logic [ALUCTRL_W-1:0] ALUControl;
  logic [3:0]           State;
  logic                 IllegalOp;

  modport master (
    input  Opcode, Funct, Zero, MemReady,
    output IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg, ALUSrcA, PCEn,
           ALUSrcB, PCSrc, ALUControl, State, IllegalOp
  );

  modport slave (
    output Opcode, Funct, Zero, MemReady,
    input  IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg, ALUSrcA, PCEn,
           ALUSrcB, PCSrc, ALUControl, State, IllegalOp
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Moore-style control FSM for a MIPS multicycle datapath (lw, sw, R-type, beq, bne, addi, j).
// Outputs decode the current state; only PCEn, IRWrite and MemWrite also look at MemReady/Zero.
module multicycle_control_unit #(
  parameter int ALUCTRL_W     = 3,
  parameter int MEM_HANDSHAKE = 1
) (
  input logic                       clk,
  input logic                       reset,
  multicycle_control_unit_if.master bus
);
  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  // Returns {illegal, alu_code}; unknown Funct falls back to add.
  function automatic logic [3:0] funct_decode(input logic [5:0] funct);
    case (funct)
      6'b100000: return {1'b0, 3'b010};
      6'b100010: return {1'b0, 3'b110};
      6'b100100: return {1'b0, 3'b000};
      6'b100101: return {1'b0, 3'b001};
      6'b101010: return {1'b0, 3'b111};
      default:   return {1'b1, 3'b010};
    endcase
  endfunction

  state_t               state, state_next;
  logic                 mem_ready;
  logic [3:0]           fdec;
  logic                 iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca, pcen;
  logic [1:0]           alusrcb, pcsrc;
  logic [2:0]           alu_ctrl;
  logic                 illegal;
  logic [ALUCTRL_W-1:0] alu_ctrl_ext;

  // Without a handshake every memory access is treated as completing immediately.
  assign mem_ready = (MEM_HANDSHAKE != 0) ? bus.MemReady : 1'b1;
  assign fdec      = funct_decode(bus.Funct);

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: default assignment first, so no path through the case can infer a latch.
    state_next = FETCH;
    case (state)
      FETCH:   state_next = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (bus.Opcode)
          OP_LW, OP_SW:   state_next = MEMADR;
          OP_RTYPE:       state_next = EXECUTE;
          OP_BEQ, OP_BNE: state_next = BRANCH;
          OP_ADDI:        state_next = ADDIEX;
          OP_J:           state_next = JUMP;
          default:        state_next = FETCH;
        endcase
      end
      MEMADR:  state_next = (bus.Opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   state_next = mem_ready ? MEMWB : MEMRD;
      MEMWR:   state_next = mem_ready ? FETCH : MEMWR;
      EXECUTE: state_next = ALUWB;
      ADDIEX:  state_next = ADDIWB;
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    iord     = 1'b0;
    irwrite  = 1'b0;
    memwrite = 1'b0;
    regwrite = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    alusrca  = 1'b0;
    pcen     = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    alu_ctrl = ALU_ADD;
    illegal  = 1'b0;
    case (state)
      FETCH: begin
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcen    = mem_ready;
      end
      DECODE: begin
        alusrcb = 2'b11;
        illegal = !(bus.Opcode inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_J});
      end
      MEMADR, ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = mem_ready;
      end
      EXECUTE: begin
        alusrca  = 1'b1;
        alu_ctrl = fdec[2:0];
        illegal  = fdec[3];
      end
      ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BRANCH: begin
        alusrca  = 1'b1;
        alu_ctrl = ALU_SUB;
        pcsrc    = 2'b01;
        pcen     = (bus.Opcode == OP_BNE) ? !bus.Zero : bus.Zero;
      end
      ADDIWB: regwrite = 1'b1;
      JUMP: begin
        pcsrc = 2'b10;
        pcen  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    alu_ctrl_ext      = '0;
    alu_ctrl_ext[2:0] = alu_ctrl;
  end

  assign bus.IorD       = iord;
  assign bus.IRWrite    = irwrite;
  assign bus.MemWrite   = memwrite;
  assign bus.RegWrite   = regwrite;
  assign bus.RegDst     = regdst;
  assign bus.MemtoReg   = memtoreg;
  assign bus.ALUSrcA    = alusrca;
  assign bus.PCEn       = pcen;
  assign bus.ALUSrcB    = alusrcb;
  assign bus.PCSrc      = pcsrc;
  assign bus.ALUControl = alu_ctrl_ext;
  assign bus.State      = state;
  assign bus.IllegalOp  = illegal;
endmodule
